// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// In-order writeback buffer that sits in front of a single register file
// write port. Writebacks are queued as {rd, data} entries and drained one
// per cycle whenever the register file is not stalled. Pending entries can
// be searched for operand bypass, and the youngest matching entry wins.
//
// Ports
//   clk              single clock, rising-edge state updates
//   reset            asynchronous active-high reset
//   in_valid         writeback request offered
//   in_ready         queue has a free entry (count < DEPTH)
//   in_rd, in_data   destination register index and value of the request
//   rf_stall         register file write port unavailable this cycle
//   rf_rd_addr       head entry register index (0 when empty)
//   rf_write_data    head entry value (0 when empty)
//   rf_write_enable  head entry is being written this cycle
//   q_rs_addr/q_rt_addr  operand lookup addresses
//   q_rs_hit/q_rt_hit    a pending write to that address exists
//   q_rs_data/q_rt_data  youngest pending value for that address (0 on miss)
//   count            number of occupied entries
//   drop_err         sticky: a request was offered while the queue was full
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [63:0]              in_data,
  input  logic                     rf_stall,
  output logic [4:0]               rf_rd_addr,
  output logic [63:0]              rf_write_data,
  output logic                     rf_write_enable,
  input  logic [4:0]               q_rs_addr,
  input  logic [4:0]               q_rt_addr,
  output logic                     q_rs_hit,
  output logic                     q_rt_hit,
  output logic [63:0]              q_rs_data,
  output logic [63:0]              q_rt_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [4:0]    rd_mem   [DEPTH];
  logic [63:0]   data_mem [DEPTH];
  logic          push;
  logic          pop;
  logic          empty;
  logic [AW-1:0] idx;

  // Handshake and drain control. There is no pass-through when full, so a
  // request arriving at full is refused even if the head drains that cycle.
  always_comb begin
    empty           = (count == '0);
    in_ready        = (count < CW'(DEPTH));
    rf_write_enable = !empty && !rf_stall;
    push            = in_valid && in_ready;
    pop             = rf_write_enable;
  end

  // Head entry presented to the register file; forced to zero when empty so
  // stale storage never leaks onto the write port.
  always_comb begin
    rf_rd_addr    = '0;
    rf_write_data = '0;
    if (!empty) begin
      rf_rd_addr    = rd_mem[head];
      rf_write_data = data_mem[head];
    end
  end

  // Bypass search. Entries are walked from oldest (head) to youngest, so a
  // later match overwrites an earlier one and the youngest value wins. Only
  // occupied slots are considered, which keeps the head visible during its
  // pop cycle and hides the entry being pushed until the next cycle.
  always_comb begin
    q_rs_hit  = 1'b0;
    q_rs_data = '0;
    q_rt_hit  = 1'b0;
    q_rt_data = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if (CW'(k) < count) begin
        if (rd_mem[idx] == q_rs_addr) begin
          q_rs_hit  = 1'b1;
          q_rs_data = data_mem[idx];
        end
        if (rd_mem[idx] == q_rt_addr) begin
          q_rt_hit  = 1'b1;
          q_rt_data = data_mem[idx];
        end
      end
    end
  end

  // Entry storage. Not reset: occupancy is tracked by count, and every
  // output derived from storage is gated by it.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= in_rd;
      data_mem[tail] <= in_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue
// Directed bench for regfile_wb_queue (DEPTH = 4). Inputs are driven 1 ns
// after each rising edge and outputs are checked before the next edge.
module tb_regfile_wb_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [63:0] in_data;
  logic        rf_stall;
  logic [4:0]  rf_rd_addr;
  logic [63:0] rf_write_data;
  logic        rf_write_enable;
  logic [4:0]  q_rs_addr;
  logic [4:0]  q_rt_addr;
  logic        q_rs_hit;
  logic        q_rt_hit;
  logic [63:0] q_rs_data;
  logic [63:0] q_rt_data;
  logic [2:0]  count;
  logic        drop_err;

  int compared   = 0;
  int mismatched = 0;
  int writes31   = 0;

  localparam logic [63:0] DATA1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] VAL_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] VAL_B = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] VAL_C = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] VAL_D = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] VAL_E = 64'hEEEE_EEEE_EEEE_EEEE;

  regfile_wb_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd           (in_rd),
    .in_data         (in_data),
    .rf_stall        (rf_stall),
    .rf_rd_addr      (rf_rd_addr),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .q_rs_addr       (q_rs_addr),
    .q_rt_addr       (q_rt_addr),
    .q_rs_hit        (q_rs_hit),
    .q_rt_hit        (q_rt_hit),
    .q_rs_data       (q_rs_data),
    .q_rt_data       (q_rt_data),
    .count           (count),
    .drop_err        (drop_err)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every register file write of R31 so the stall-toggle step can
  // confirm the write happened exactly once.
  always @(posedge clk) begin
    if (rf_write_enable && rf_rd_addr == 5'd31) writes31 <= writes31 + 1;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rd,
                               input logic [63:0] data, input logic stall,
                               input logic [4:0] rs, input logic [4:0] rt);
    in_valid  = v;
    in_rd     = rd;
    in_data   = data;
    rf_stall  = stall;
    q_rs_addr = rs;
    q_rt_addr = rt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_we", 64'(rf_write_enable), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_addr", 64'(rf_rd_addr), 64'd0);
    checkOutput("rst_wdata", rf_write_data, 64'd0);
    checkOutput("rst_hits", 64'({q_rs_hit, q_rt_hit}), 64'd0);
    checkOutput("rst_drop", 64'(drop_err), 64'd0);
    @(posedge clk);
    #7 reset = 1'b0;

    // Single write; pushed request is invisible to lookups in its push cycle
    $display("[TB] single write");
    applyStimulus(1, 5'd1, DATA1, 0, 5'd1, 5'd0);
    checkOutput("push_not_visible", 64'(q_rs_hit), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd1, 5'd0);
    checkOutput("single_we", 64'(rf_write_enable), 64'd1);
    checkOutput("single_addr", 64'(rf_rd_addr), 64'd1);
    checkOutput("single_data", rf_write_data, DATA1);
    checkOutput("single_bypass", q_rs_data, DATA1);
    tick();
    checkOutput("single_count0", 64'(count), 64'd0);
    checkOutput("single_we0", 64'(rf_write_enable), 64'd0);

    // Fill under stall, then overflow
    $display("[TB] fill and overflow");
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(1, 5'(i), 64'(100 + i), 1, 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1, 5'd6, 64'd106, 1, 5'd2, 5'd6);
    checkOutput("full_count", 64'(count), 64'd4);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_stalled_we", 64'(rf_write_enable), 64'd0);
    checkOutput("full_drop_before", 64'(drop_err), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd2, 5'd6);
    checkOutput("ovf_drop", 64'(drop_err), 64'd1);
    checkOutput("ovf_count", 64'(count), 64'd4);
    checkOutput("ovf_dropped_miss", 64'(q_rt_hit), 64'd0);
    checkOutput("head_visible_pop", 64'(q_rs_hit), 64'd1);
    checkOutput("head_visible_data", q_rs_data, 64'd102);
    for (int i = 2; i <= 5; i++) begin
      checkOutput("drain_we", 64'(rf_write_enable), 64'd1);
      checkOutput("drain_addr", 64'(rf_rd_addr), 64'(i));
      checkOutput("drain_data", rf_write_data, 64'(100 + i));
      tick();
    end
    checkOutput("drain_count0", 64'(count), 64'd0);
    checkOutput("drop_sticky", 64'(drop_err), 64'd1);

    // Clear with reset between edges
    reset = 1'b1;
    #2;
    checkOutput("reset_clears_drop", 64'(drop_err), 64'd0);
    reset = 1'b0;

    // Bypass youngest
    $display("[TB] bypass youngest");
    applyStimulus(1, 5'd7, VAL_A, 1, 5'd7, 5'd8);
    tick();
    applyStimulus(1, 5'd7, VAL_B, 1, 5'd7, 5'd8);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd7, 5'd8);
    checkOutput("byp_rs_hit", 64'(q_rs_hit), 64'd1);
    checkOutput("byp_rs_data", q_rs_data, VAL_B);
    checkOutput("byp_rt_hit", 64'(q_rt_hit), 64'd0);
    checkOutput("byp_rt_data", q_rt_data, 64'd0);
    applyStimulus(1, 5'd9, VAL_C, 1, 5'd7, 5'd9);
    tick();
    applyStimulus(1, 5'd10, VAL_D, 1, 5'd9, 5'd10);
    checkOutput("byp_rs9", q_rs_data, VAL_C);
    checkOutput("byp_pushing_hidden", 64'(q_rt_hit), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd7, 5'd10);
    checkOutput("byp_rt10", q_rt_data, VAL_D);

    // Simultaneous push and pop with pointer wrap
    $display("[TB] push and pop");
    checkOutput("pp_full_ready", 64'(in_ready), 64'd0);
    checkOutput("pp_head_addr", 64'(rf_rd_addr), 64'd7);
    checkOutput("pp_head_data", rf_write_data, VAL_A);
    checkOutput("pp_rs_head_still_b", q_rs_data, VAL_B);
    tick();
    checkOutput("pp_count3", 64'(count), 64'd3);
    checkOutput("pp_ready1", 64'(in_ready), 64'd1);
    begin
      logic [4:0]  exp_addr [4];
      logic [63:0] exp_data [4];
      exp_addr = '{5'd7, 5'd9, 5'd10, 5'd11};
      exp_data = '{VAL_B, VAL_C, VAL_D, 64'h1000};
      for (int j = 0; j < 4; j++) begin
        applyStimulus(1, 5'(11 + j), 64'h1000 + 64'(j), 0, 5'd0, 5'd0);
        checkOutput("pp_count", 64'(count), 64'd3);
        checkOutput("pp_addr", 64'(rf_rd_addr), 64'(exp_addr[j]));
        checkOutput("pp_data", rf_write_data, exp_data[j]);
        tick();
      end
    end
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0);
    checkOutput("pp_no_drop", 64'(drop_err), 64'd0);
    for (int j = 1; j <= 3; j++) begin
      checkOutput("pp_wrap_addr", 64'(rf_rd_addr), 64'(11 + j));
      checkOutput("pp_wrap_data", rf_write_data, 64'h1000 + 64'(j));
      tick();
    end
    checkOutput("pp_empty", 64'(count), 64'd0);

    // Reset mid-operation
    $display("[TB] reset mid-operation");
    for (int i = 20; i <= 22; i++) begin
      applyStimulus(1, 5'(i), 64'(i), 1, 5'd0, 5'd0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 5'd20, 5'd0);
    checkOutput("mid_we_before", 64'(rf_write_enable), 64'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_we_fall", 64'(rf_write_enable), 64'd0);
    checkOutput("mid_count0", 64'(count), 64'd0);
    checkOutput("mid_addr0", 64'(rf_rd_addr), 64'd0);
    checkOutput("mid_hit0", 64'(q_rs_hit), 64'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mid_no_write", 64'(rf_write_enable), 64'd0);
    end

    // Stall toggle: R31 written only in an unstalled cycle, exactly once
    $display("[TB] stall toggle");
    applyStimulus(1, 5'd31, VAL_E, 1, 5'd0, 5'd0);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd0);
    checkOutput("tog_stalled_we", 64'(rf_write_enable), 64'd0);
    tick();
    checkOutput("tog_held_count", 64'(count), 64'd1);
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0);
    checkOutput("tog_we", 64'(rf_write_enable), 64'd1);
    checkOutput("tog_addr", 64'(rf_rd_addr), 64'd31);
    checkOutput("tog_data", rf_write_data, VAL_E);
    tick();
    applyStimulus(0, 0, 0, 1, 5'd0, 5'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0);
    checkOutput("tog_after_we", 64'(rf_write_enable), 64'd0);
    tick();
    checkOutput("tog_write_once", 64'(writes31), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
